// File: rtl/aes128_decrypt_serial.sv
// Byte-serial AES-128 inverse cipher fed a pre-expanded key schedule K10..K0.
// Ports: clock, resetn, enable, in[7:0], key[7:0] -> message[127:0], busy, done.
module aes128_decrypt_serial (
  input  logic         clock,
  input  logic         resetn,
  input  logic         enable,
  input  logic [7:0]   in,
  input  logic [7:0]   key,
  output logic [127:0] message,
  output logic         busy,
  output logic         done
);

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t     fsm;
  logic [7:0] st  [16];
  logic [7:0] isr [16];
  logic [7:0] mc  [4];
  logic       en_q;
  logic [3:0] idx;
  logic [6:0] ph;
  logic [3:0] rnd;
  logic [3:0] sb_idx;
  logic [3:0] k_idx;
  logic [1:0] col;

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [10:0] b;
    b = {~x, 3'b000};
    return INV_SBOX[b +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // c selects which of x*8, x*4, x*2, x*1 are summed
  function automatic logic [7:0] gm(input logic [7:0] x,
                                    input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^
           (c[1] ? x2 : 8'h00) ^ (c[0] ? x  : 8'h00);
  endfunction

  // Phase offsets: sub-bytes at 1..16, key at 45..60, mix at 61..64
  assign sb_idx = ph[3:0] - 4'd1;
  assign k_idx  = ph[3:0] - 4'd13;
  assign col    = ph[1:0] - 2'd1;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        isr[r + 4*c] = st[r + 4*((c - r + 4) % 4)];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      mc[j] = gm(st[{col, 2'(j)}],           4'he) ^
              gm(st[{col, 2'((j + 1) % 4)}], 4'hb) ^
              gm(st[{col, 2'((j + 2) % 4)}], 4'hd) ^
              gm(st[{col, 2'((j + 3) % 4)}], 4'h9);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fsm     <= IDLE;
      message <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      en_q    <= 1'b0;
      idx     <= '0;
      ph      <= '0;
      rnd     <= '0;
      for (int i = 0; i < 16; i++) st[i] <= '0;
    end else begin
      en_q <= enable;
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          // rising enable only; a held-high enable never restarts
          if (enable && !en_q) begin
            st[0] <= in ^ key;
            idx   <= 4'd1;
            busy  <= 1'b1;
            fsm   <= LOAD;
          end
        end
        LOAD: begin
          if (!enable) begin
            busy <= 1'b0;
            fsm  <= IDLE;
          end else begin
            st[idx] <= in ^ key;
            idx     <= idx + 4'd1;
            if (idx == 4'd15) begin
              ph  <= '0;
              rnd <= '0;
              fsm <= RUN;
            end
          end
        end
        RUN: begin
          if (!enable) begin
            busy <= 1'b0;
            fsm  <= IDLE;
          end else begin
            ph <= ph + 7'd1;
            if (ph == 7'd0) st <= isr;
            if (ph >= 7'd1 && ph <= 7'd16)
              st[sb_idx] <= inv_sbox(st[sb_idx]);
            if (ph >= 7'd45 && ph <= 7'd60)
              st[k_idx] <= st[k_idx] ^ key;
            if (ph >= 7'd61 && ph <= 7'd64 && rnd != 4'd9) begin
              for (int j = 0; j < 4; j++) st[{col, 2'(j)}] <= mc[j];
            end
            if (ph == 7'd61 && rnd == 4'd9) begin
              for (int i = 0; i < 16; i++)
                message[127 - 8*i -: 8] <= st[i];
              done <= 1'b1;
              busy <= 1'b0;
              fsm  <= IDLE;
            end
            if (ph == 7'd80) begin
              ph  <= '0;
              rnd <= rnd + 4'd1;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decrypt_serial.sv
// Bench for aes128_decrypt_serial: ciphertexts come from a forward AES model,
// the DUT must recover the plaintext on the fixed key-window schedule.
module tb_aes128_decrypt_serial;

  logic         clock = 1'b0;
  logic         resetn;
  logic         enable;
  logic [7:0]   in;
  logic [7:0]   key;
  logic [127:0] message;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb [256];
  logic [7:0] rk [11][16];

  aes128_decrypt_serial decrypt (
    .clock   (clock),
    .resetn  (resetn),
    .enable  (enable),
    .in      (in),
    .key     (key),
    .message (message),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] v;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      sb[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^
              {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] ^= rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      for (int b = 0; b < 16; b++)
        rk[r][b] = w[4*r + b/4][31 - 8*(b%4) -: 8];
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[0][i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++)
          t[row + 4*c] = s[row + 4*((c + row) % 4)];
      s = t;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          t[4*c]   = gmul(s[4*c], 2) ^ gmul(s[4*c+1], 3) ^ s[4*c+2] ^ s[4*c+3];
          t[4*c+1] = s[4*c] ^ gmul(s[4*c+1], 2) ^ gmul(s[4*c+2], 3) ^ s[4*c+3];
          t[4*c+2] = s[4*c] ^ s[4*c+1] ^ gmul(s[4*c+2], 2) ^ gmul(s[4*c+3], 3);
          t[4*c+3] = gmul(s[4*c], 3) ^ s[4*c+1] ^ s[4*c+2] ^ gmul(s[4*c+3], 2);
        end
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] ^= rk[r][i];
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  // K10 on cycles 0..15, Kr at 61 + 81*(9-r) + i, noise elsewhere
  function automatic logic [7:0] key_at(input int n);
    int m;
    if (n < 16) return rk[10][n];
    m = n - 61;
    if (m >= 0 && m / 81 <= 9 && m % 81 < 16) return rk[9 - m/81][m % 81];
    return 8'($urandom);
  endfunction

  task automatic idle(input int cyc, output int nd);
    nd = 0;
    enable = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      in  = 8'($urandom);
      key = 8'($urandom);
      @(posedge clock);
      @(negedge clock);
      if (done) nd++;
    end
  endtask

  task automatic run(input logic [127:0] ct, input int stop_at,
                     input int rst_at, input int hold,
                     output int done_at, output int nd);
    done_at = -1;
    nd = 0;
    for (int n = 0; n <= 806 + hold; n++) begin
      enable = !(stop_at >= 0 && n >= stop_at);
      in  = (n < 16) ? ct[127 - 8*n -: 8] : 8'($urandom);
      key = key_at(n);
      @(posedge clock);
      @(negedge clock);
      if (done) begin
        nd++;
        if (done_at < 0) done_at = n;
      end
      if (n == 0)   chk("busy_cycle0", busy, 1);
      if (n == 805) chk("busy_cycle805", busy, 1);
      if (n == 806 + hold) chk("busy_after_done", busy, 0);
      if (n == stop_at) break;
      if (n == rst_at) begin
        resetn = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_msg", message, 0);
        break;
      end
    end
    enable = 1'b0;
  endtask

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    int           da, nd, ni;
    logic [127:0] k10, kr, pt, ct;

    resetn = 1'b0;
    enable = 1'b0;
    in     = 8'h00;
    key    = 8'h00;
    build_sbox();
    #12;
    chk("rst_msg", message, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clock);
    resetn = 1'b1;
    idle(20, ni);
    chk("idle_msg", message, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done_cnt", ni, 0);

    expand(K1);
    for (int i = 0; i < 16; i++) k10[127 - 8*i -: 8] = rk[10][i];
    chk("schedule_k10", k10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run(CT1, -1, -1, 4, da, nd);
    chk("fips_done_at", da, 806);
    chk("fips_done_cnt", nd, 1);
    chk("fips_msg", message, PT1);

    idle(2, ni);
    expand(128'h0);
    run(CT2, -1, -1, 0, da, nd);
    chk("zero_done_at", da, 806);
    chk("zero_done_cnt", nd, 1);
    chk("zero_msg", message, 0);

    idle(2, ni);
    expand(K1);
    run(CT1, -1, 300, 0, da, nd);
    idle(3, ni);
    chk("rst_mid_done_cnt", nd + ni, 0);
    resetn = 1'b1;
    idle(5, ni);
    chk("rst_mid_msg", message, 0);

    run(CT1, -1, -1, 0, da, nd);
    chk("pre_abort_msg", message, PT1);
    idle(2, ni);
    expand(128'h0);
    run(CT2, 400, -1, 0, da, nd);
    chk("abort_busy", busy, 0);
    idle(20, ni);
    chk("abort_done_cnt", nd + ni, 0);
    chk("abort_msg", message, PT1);

    expand(K1);
    idle(1, ni);
    run(CT1, -1, -1, 30, da, nd);
    chk("hold_done_cnt", nd, 1);
    chk("hold_msg", message, PT1);
    idle(1, ni);
    expand(128'h0);
    run(CT2, -1, -1, 0, da, nd);
    chk("restart_done_at", da, 806);
    chk("restart_msg", message, 0);

    for (int t = 0; t < 3; t++) begin
      kr = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      expand(kr);
      ct = encrypt(pt);
      idle(1, ni);
      run(ct, -1, -1, 0, da, nd);
      chk("rand_done_at", da, 806);
      chk("rand_msg", message, pt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
